// File: rtl/if_fetch_pc.sv
// Fetch-stage PC register and single-outstanding instruction request unit.
// Buffers one fetched {pc,instr} for ID and drops stale fetches on redirect.
module if_fetch_pc #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] next_pc_i,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [31:0]     if_instr_o,
    input  logic            id_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] buf_pc;
    logic [31:0]     buf_instr;
    logic            buf_valid;
    logic            kill_q;

    logic            consume;
    logic            fire;
    logic [XLEN-1:0] next_pc;

    // Instructions are word aligned; low bits from the mux are dropped.
    assign next_pc     = next_pc_i & ~XLEN'(3);
    assign consume     = buf_valid & id_ready_i;
    assign imem_req_o  = (state == REQ) & ~redirect_i
                       & (~buf_valid | id_ready_i);
    assign fire        = imem_req_o & imem_gnt_i;

    assign pc_plus4_o  = pc_q + XLEN'(4);
    assign imem_addr_o = pc_q;
    assign if_valid_o  = buf_valid;
    assign if_pc_o     = buf_pc;
    assign if_instr_o  = buf_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            buf_pc    <= '0;
            buf_instr <= '0;
            buf_valid <= 1'b0;
            kill_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (redirect_i) begin
                        pc_q      <= next_pc;
                        buf_valid <= 1'b0;
                    end else begin
                        if (consume)
                            buf_valid <= 1'b0;
                        if (fire) begin
                            req_pc_q <= pc_q;
                            pc_q     <= next_pc;
                            state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (consume || redirect_i)
                        buf_valid <= 1'b0;
                    if (redirect_i)
                        pc_q <= next_pc;
                    if (imem_rvalid_i) begin
                        // A response racing a redirect is stale as well.
                        if (!kill_q && !redirect_i) begin
                            buf_valid <= 1'b1;
                            buf_pc    <= req_pc_q;
                            buf_instr <= imem_rdata_i;
                        end
                        kill_q <= 1'b0;
                        state  <= REQ;
                    end else if (redirect_i) begin
                        kill_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_pc.sv
// Bench for if_fetch_pc: directed vector table, corner sequences and a
// randomized run against an in-order program model.
module tb_if_fetch_pc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Next-PC 2:1 mux outside the unit
    assign next_pc = redirect ? target : pc_plus4;

    if_fetch_pc #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect_i   (redirect),
        .next_pc_i    (next_pc),
        .pc_plus4_o   (pc_plus4),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .if_valid_o   (if_valid),
        .if_pc_o      (if_pc),
        .if_instr_o   (if_instr),
        .id_ready_i   (id_ready)
    );

    typedef struct {
        logic        redir;
        logic [31:0] tgt;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t tbl[20];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rd, input logic [31:0] tg,
                         input logic g, input logic rv,
                         input logic [31:0] d, input logic rdy);
        @(negedge clk);
        redirect    = rd;
        target      = tg;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = d;
        id_ready    = rdy;
        #1;
    endtask

    task automatic idle_inputs();
        redirect    = 1'b0;
        target      = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        id_ready    = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_plus4"}, pc_plus4, 32'h4);
        chk({tag, "_pc"}, if_pc, 32'h0);
        chk({tag, "_instr"}, if_instr, 32'h0);
    endtask

    // Release lands mid-cycle so the next drive() is the IDLE cycle.
    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(tag);
        release_reset();
    endtask

    // Random-phase model state
    logic [31:0] exp_req_pc, exp_del_pc, pend_addr, prev_pc, prev_instr;
    logic        pending, prev_vld, prev_rdy, prev_redir;
    int          cnt, delivered;

    initial begin
        tbl[0]  = '{0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   32'h0};
        tbl[1]  = '{0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0,   32'h0};
        tbl[2]  = '{0, 32'h0,   0, 1, 32'h13,  1, 0, 32'h4,   0, 32'h0,   32'h0};
        tbl[3]  = '{0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h4,   1, 32'h0,   32'h13};
        tbl[4]  = '{0, 32'h0,   0, 1, 32'hA,   1, 0, 32'h8,   0, 32'h0,   32'h0};
        tbl[5]  = '{0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h8,   1, 32'h4,   32'hA};
        tbl[6]  = '{1, 32'h100, 0, 0, 32'h0,   1, 0, 32'hC,   0, 32'h0,   32'h0};
        tbl[7]  = '{0, 32'h0,   0, 1, 32'hBAD, 1, 0, 32'h100, 0, 32'h0,   32'h0};
        tbl[8]  = '{0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h100, 0, 32'h0,   32'h0};
        tbl[9]  = '{0, 32'h0,   0, 1, 32'h11,  1, 0, 32'h104, 0, 32'h0,   32'h0};
        tbl[10] = '{0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h104, 1, 32'h100, 32'h11};
        tbl[11] = '{0, 32'h0,   0, 1, 32'h22,  1, 0, 32'h108, 0, 32'h0,   32'h0};
        tbl[12] = '{0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h108, 1, 32'h104, 32'h22};
        tbl[13] = '{0, 32'h0,   0, 1, 32'h33,  1, 0, 32'h10C, 0, 32'h0,   32'h0};
        tbl[14] = '{1, 32'h203, 1, 0, 32'h0,   1, 0, 32'h10C, 1, 32'h108, 32'h33};
        tbl[15] = '{0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h200, 0, 32'h0,   32'h0};
        tbl[16] = '{0, 32'h0,   0, 1, 32'h44,  1, 0, 32'h204, 0, 32'h0,   32'h0};
        tbl[17] = '{0, 32'h0,   1, 0, 32'h0,   0, 0, 32'h204, 1, 32'h200, 32'h44};
        tbl[18] = '{0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h204, 1, 32'h200, 32'h44};
        tbl[19] = '{0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h204, 0, 32'h0,   32'h0};

        // Vector table: first fetch, redirect in RESP, redirect on gnt
        do_reset("rst_a");
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].redir, tbl[i].tgt, tbl[i].gnt, tbl[i].rv,
                  tbl[i].rdata, tbl[i].rdy);
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].pc);
                chk($sformatf("tbl%0d_instr", i), if_instr, tbl[i].instr);
            end
        end

        // Stall with a full buffer, then stream resumes
        do_reset("rst_b");
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 1);
        chk("st_req0", 32'(imem_req), 32'd1);
        chk("st_addr0", imem_addr, 32'h0);
        drive(0, 0, 0, 1, mem(32'h0), 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            chk("st_hold_req", 32'(imem_req), 32'd0);
            chk("st_hold_valid", 32'(if_valid), 32'd1);
            chk("st_hold_pc", if_pc, 32'h0);
        end
        drive(0, 0, 1, 0, 0, 1);
        chk("st_resume_req", 32'(imem_req), 32'd1);
        chk("st_resume_addr", imem_addr, 32'h4);
        chk("st_resume_instr", if_instr, mem(32'h0));
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 0, 1, mem(32'(4 * k)), 1);
            chk("st_resp_req", 32'(imem_req), 32'd0);
            drive(0, 0, 1, 0, 0, 1);
            chk("st_valid", 32'(if_valid), 32'd1);
            chk("st_pc", if_pc, 32'(4 * k));
            chk("st_instr", if_instr, mem(32'(4 * k)));
            chk("st_next_addr", imem_addr, 32'(4 * k + 4));
        end

        // Redirect with rvalid in the same cycle, then with a full buffer
        drive(1, 32'h300, 0, 1, mem(32'h10), 1);
        chk("rr_req", 32'(imem_req), 32'd0);
        drive(0, 0, 1, 0, 0, 1);
        chk("rr_valid", 32'(if_valid), 32'd0);
        chk("rr_req_tgt", 32'(imem_req), 32'd1);
        chk("rr_addr_tgt", imem_addr, 32'h300);
        drive(0, 0, 0, 1, mem(32'h300), 1);
        drive(0, 0, 1, 0, 0, 0);
        chk("rb_valid", 32'(if_valid), 32'd1);
        chk("rb_pc", if_pc, 32'h300);
        drive(1, 32'h400, 0, 0, 0, 0);
        chk("rb_req", 32'(imem_req), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rb_flush", 32'(if_valid), 32'd0);
        chk("rb_addr", imem_addr, 32'h400);

        // Reset in RESP, late rvalid after release
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        idle_inputs();
        release_reset();
        drive(0, 0, 0, 1, 32'hDEAD, 1);
        chk("late_req_idle", 32'(imem_req), 32'd0);
        drive(0, 0, 0, 1, 32'hDEAD, 1);
        chk("late_req", 32'(imem_req), 32'd1);
        chk("late_addr", imem_addr, 32'h0);
        drive(0, 0, 0, 0, 0, 1);
        chk("late_valid", 32'(if_valid), 32'd0);
        chk("late_addr2", imem_addr, 32'h0);

        // Random run: delivered stream must be the in-order program
        do_reset("rst_r");
        exp_req_pc = 32'h0;
        exp_del_pc = 32'h0;
        pending    = 1'b0;
        pend_addr  = '0;
        cnt        = 0;
        delivered  = 0;
        prev_vld   = 1'b0;
        prev_rdy   = 1'b1;
        prev_redir = 1'b0;
        prev_pc    = '0;
        prev_instr = '0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            redirect = ($urandom_range(15) == 0);
            if ($urandom_range(3) == 0)
                target = 32'hFFFF_FFF8 | 32'($urandom_range(7));
            else
                target = $urandom;
            imem_gnt    = 1'($urandom_range(1));
            imem_rvalid = pending && (cnt == 0);
            imem_rdata  = mem(pend_addr);
            id_ready    = ($urandom_range(9) < 7);
            #1;
            if (redirect)
                chk("rnd_req_on_redirect", 32'(imem_req), 32'd0);
            if (prev_redir) begin
                chk("rnd_flush", 32'(if_valid), 32'd0);
            end else if (prev_vld && !prev_rdy) begin
                chk("rnd_hold_valid", 32'(if_valid), 32'd1);
                chk("rnd_hold_pc", if_pc, prev_pc);
                chk("rnd_hold_instr", if_instr, prev_instr);
            end
            if (if_valid && !id_ready)
                chk("rnd_req_full", 32'(imem_req), 32'd0);
            if (imem_req && imem_gnt)
                chk("rnd_req_addr", imem_addr, exp_req_pc);
            if (if_valid && id_ready) begin
                chk("rnd_del_pc", if_pc, exp_del_pc);
                chk("rnd_del_instr", if_instr, mem(exp_del_pc));
                exp_del_pc = exp_del_pc + 32'd4;
                delivered++;
            end
            prev_vld   = if_valid;
            prev_rdy   = id_ready;
            prev_redir = redirect;
            prev_pc    = if_pc;
            prev_instr = if_instr;
            if (imem_rvalid)
                pending = 1'b0;
            else if (pending)
                cnt--;
            if (redirect) begin
                exp_req_pc = target & ~32'd3;
                exp_del_pc = target & ~32'd3;
            end else if (imem_req && imem_gnt) begin
                exp_req_pc = exp_req_pc + 32'd4;
                pending    = 1'b1;
                pend_addr  = imem_addr;
                cnt        = $urandom_range(3);
            end
        end
        chk("rnd_progress", 32'(delivered >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
